hazard_ctrl: RTL and testbench

- Parametrised pipeline hazard controller for the 5-stage MIPS core, sitting between the decode stage and the pipeline latch enables and flushes.
- Holds an internal destination-register scoreboard for the EX, MEM and WB stages. From it the block generates load-use or full-RAW stalls, forwarding selects, branch flushes and memory-wait freezes.
- A small FSM sequences memory waits and halt drain, and a saturating counter reports stall cycles.

---
 rtl/hazard_ctrl.sv | 160 ++++++++++++++++
 tb/tb_hazard_ctrl.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: EX/MEM/WB destination scoreboard driving stalls, forwarding,
// branch flushes, memory-wait freezes and HALT drain for the 5-stage core.
module hazard_ctrl #(
  parameter int unsigned REG_W     = 5,
  parameter bit          FWD_EN    = 1'b1,
  parameter bit          WB_BYPASS = 1'b1,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic             dmem_req,
  input  logic             dhit,
  input  logic [REG_W-1:0] dec_rs,
  input  logic [REG_W-1:0] dec_rt,
  input  logic             dec_use_rs,
  input  logic             dec_use_rt,
  input  logic [REG_W-1:0] dec_wsel,
  input  logic             dec_wen,
  input  logic             dec_load,
  input  logic             dec_halt,
  input  logic             ex_redirect,
  output logic             pcEN,
  output logic             fdEN,
  output logic             dxEN,
  output logic             xmEN,
  output logic             mwEN,
  output logic             fd_flush,
  output logic             dx_flush,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef struct packed {
    logic             v;
    logic [REG_W-1:0] wsel;
    logic             load;
  } sb_t;

  typedef enum logic [1:0] {StRun, StMemWait, StDrain, StHalted} state_e;

  state_e           state_q;
  sb_t              sb1_q, sb2_q, sb3_q;
  logic             halted_q;
  logic [CNT_W-1:0] cnt_q;

  logic m1_a, m2_a, m3_a, m1_b, m2_b, m3_b;
  logic mem_stall, raw_stall, run_like, halt_acc, sb_empty;

  function automatic logic hit(input sb_t e, input logic used, input logic [REG_W-1:0] r);
    return used && e.v && (e.wsel == r) && (r != '0);
  endfunction

  // Youngest producer wins; a load in EX cannot forward yet (that case stalls instead).
  function automatic logic [1:0] fwd_sel(input logic m1, input logic m1_load, input logic m2);
    if (!FWD_EN)            return 2'd0;
    else if (m1 && !m1_load) return 2'd1;
    else if (m2)             return 2'd2;
    else                     return 2'd0;
  endfunction

  assign m1_a = hit(sb1_q, dec_use_rs, dec_rs);
  assign m2_a = hit(sb2_q, dec_use_rs, dec_rs);
  assign m3_a = hit(sb3_q, dec_use_rs, dec_rs);
  assign m1_b = hit(sb1_q, dec_use_rt, dec_rt);
  assign m2_b = hit(sb2_q, dec_use_rt, dec_rt);
  assign m3_b = hit(sb3_q, dec_use_rt, dec_rt);

  assign mem_stall = dmem_req && !dhit;
  assign raw_stall = FWD_EN ? ((m1_a || m1_b) && sb1_q.load)
                            : (m1_a || m1_b || m2_a || m2_b || (!WB_BYPASS && (m3_a || m3_b)));
  assign run_like  = (state_q == StRun) || (state_q == StMemWait);
  assign halt_acc  = run_like && !mem_stall && !ex_redirect && !raw_stall && dec_halt;
  assign sb_empty  = !(sb1_q.v || sb2_q.v || sb3_q.v);

  assign fwd_a     = fwd_sel(m1_a, sb1_q.load, m2_a);
  assign fwd_b     = fwd_sel(m1_b, sb1_q.load, m2_b);
  assign halted    = halted_q;
  assign stall_cnt = cnt_q;

  always_comb begin
    pcEN     = 1'b1;
    fdEN     = 1'b1;
    dxEN     = 1'b1;
    xmEN     = 1'b1;
    mwEN     = 1'b1;
    fd_flush = 1'b0;
    dx_flush = 1'b0;
    if (state_q == StHalted || mem_stall) begin
      pcEN = 1'b0;
      fdEN = 1'b0;
      dxEN = 1'b0;
      xmEN = 1'b0;
      mwEN = 1'b0;
    end else if (ex_redirect) begin
      fd_flush = 1'b1;
      dx_flush = 1'b1;
    end else if (state_q == StDrain) begin
      pcEN     = 1'b0;
      fd_flush = 1'b1;
    end else if (raw_stall) begin
      pcEN     = 1'b0;
      fdEN     = 1'b0;
      dx_flush = 1'b1;
    end else if (!ihit) begin
      pcEN     = 1'b0;
      fd_flush = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= StRun;
      halted_q <= 1'b0;
    end else begin
      case (state_q)
        StRun, StMemWait: begin
          if (mem_stall)     state_q <= StMemWait;
          else if (halt_acc) state_q <= StDrain;
          else               state_q <= StRun;
        end
        StDrain: begin
          // A redirect means the HALT was on the wrong path.
          if (!mem_stall && ex_redirect) begin
            state_q <= StRun;
          end else if (!mem_stall && sb_empty) begin
            state_q  <= StHalted;
            halted_q <= 1'b1;
          end
        end
        StHalted: state_q <= StHalted;
        default:  state_q <= StRun;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      sb1_q <= '0;
      sb2_q <= '0;
      sb3_q <= '0;
    end else if (!mem_stall && state_q != StHalted) begin
      sb3_q <= sb2_q;
      sb2_q <= sb1_q;
      if (dx_flush) sb1_q <= '0;
      else          sb1_q <= {dec_wen, dec_wsel, dec_load};
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      cnt_q <= '0;
    end else if (!pcEN && run_like && cnt_q != '1) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: three configurations share one stimulus stream; directed scenarios then
// random traffic, every cycle compared against a behavioural model of the pipeline rules.
module tb_hazard_ctrl;

  localparam int N = 3;

  logic       CLK, nRST, ihit, dmem_req, dhit;
  logic [4:0] dec_rs, dec_rt, dec_wsel;
  logic       dec_use_rs, dec_use_rt, dec_wen, dec_load, dec_halt, ex_redirect;

  logic [N-1:0]      pc_en, fd_en, dx_en, xm_en, mw_en, fd_fl, dx_fl, hlt;
  logic [N-1:0][1:0] fa, fb;
  logic [15:0]       cnt0, cnt2;
  logic [1:0]        cnt1;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic       pc, fd, dx, xm, mw, fdf, dxf;
    logic [1:0] fa, fb;
    logic       hl;
    logic [15:0] cnt;
  } obs_t;

  typedef enum int {MRun, MMemWait, MDrain, MHalted} mode_e;

  // Per-configuration model: forwarding on/off, WB bypass on/off, counter ceiling.
  localparam bit [N-1:0] CFG_FWD = 3'b001;
  localparam bit [N-1:0] CFG_BYP = 3'b011;

  mode_e      m_mode [N];
  bit         m_v    [N][3];
  logic [4:0] m_w    [N][3];
  bit         m_l    [N][3];
  int         m_cnt  [N];

  hazard_ctrl u_dut0 (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dmem_req(dmem_req), .dhit(dhit),
    .dec_rs(dec_rs), .dec_rt(dec_rt), .dec_use_rs(dec_use_rs), .dec_use_rt(dec_use_rt),
    .dec_wsel(dec_wsel), .dec_wen(dec_wen), .dec_load(dec_load), .dec_halt(dec_halt),
    .ex_redirect(ex_redirect), .pcEN(pc_en[0]), .fdEN(fd_en[0]), .dxEN(dx_en[0]),
    .xmEN(xm_en[0]), .mwEN(mw_en[0]), .fd_flush(fd_fl[0]), .dx_flush(dx_fl[0]),
    .fwd_a(fa[0]), .fwd_b(fb[0]), .halted(hlt[0]), .stall_cnt(cnt0)
  );

  hazard_ctrl #(.FWD_EN(1'b0), .WB_BYPASS(1'b1), .CNT_W(2)) u_dut1 (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dmem_req(dmem_req), .dhit(dhit),
    .dec_rs(dec_rs), .dec_rt(dec_rt), .dec_use_rs(dec_use_rs), .dec_use_rt(dec_use_rt),
    .dec_wsel(dec_wsel), .dec_wen(dec_wen), .dec_load(dec_load), .dec_halt(dec_halt),
    .ex_redirect(ex_redirect), .pcEN(pc_en[1]), .fdEN(fd_en[1]), .dxEN(dx_en[1]),
    .xmEN(xm_en[1]), .mwEN(mw_en[1]), .fd_flush(fd_fl[1]), .dx_flush(dx_fl[1]),
    .fwd_a(fa[1]), .fwd_b(fb[1]), .halted(hlt[1]), .stall_cnt(cnt1)
  );

  hazard_ctrl #(.FWD_EN(1'b0), .WB_BYPASS(1'b0)) u_dut2 (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dmem_req(dmem_req), .dhit(dhit),
    .dec_rs(dec_rs), .dec_rt(dec_rt), .dec_use_rs(dec_use_rs), .dec_use_rt(dec_use_rt),
    .dec_wsel(dec_wsel), .dec_wen(dec_wen), .dec_load(dec_load), .dec_halt(dec_halt),
    .ex_redirect(ex_redirect), .pcEN(pc_en[2]), .fdEN(fd_en[2]), .dxEN(dx_en[2]),
    .xmEN(xm_en[2]), .mwEN(mw_en[2]), .fd_flush(fd_fl[2]), .dx_flush(dx_fl[2]),
    .fwd_a(fa[2]), .fwd_b(fb[2]), .halted(hlt[2]), .stall_cnt(cnt2)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  function automatic int cnt_max(input int i);
    return (i == 1) ? 3 : 65535;
  endfunction

  function automatic bit m_match(input int i, input int k, input logic [4:0] r);
    return m_v[i][k] && (m_w[i][k] == r) && (r != 5'd0);
  endfunction

  function automatic obs_t model_out(input int i, output bit haz);
    obs_t       o;
    logic [4:0] src [2];
    bit         used [2];
    logic [1:0] f [2];
    bit         ms;
    ms = dmem_req && !dhit;
    src[0] = dec_rs;  src[1] = dec_rt;
    used[0] = dec_use_rs; used[1] = dec_use_rt;
    haz = 1'b0;
    for (int s = 0; s < 2; s++) begin
      f[s] = 2'd0;
      if (used[s]) begin
        if (CFG_FWD[i]) begin
          if (m_match(i, 0, src[s]) && m_l[i][0]) haz = 1'b1;
          if (m_match(i, 0, src[s]) && !m_l[i][0]) f[s] = 2'd1;
          else if (m_match(i, 1, src[s]))          f[s] = 2'd2;
        end else if (m_match(i, 0, src[s]) || m_match(i, 1, src[s]) ||
                     (!CFG_BYP[i] && m_match(i, 2, src[s]))) begin
          haz = 1'b1;
        end
      end
    end
    o     = '0;
    o.fa  = f[0];
    o.fb  = f[1];
    o.hl  = (m_mode[i] == MHalted);
    o.cnt = m_cnt[i][15:0];
    if (!(m_mode[i] == MHalted || ms)) begin
      {o.pc, o.fd, o.dx, o.xm, o.mw} = 5'b11111;
      if (ex_redirect)               begin o.fdf = 1'b1; o.dxf = 1'b1; end
      else if (m_mode[i] == MDrain)  begin o.pc = 1'b0;  o.fdf = 1'b1; end
      else if (haz)                  begin o.pc = 1'b0;  o.fd = 1'b0; o.dxf = 1'b1; end
      else if (!ihit)                begin o.pc = 1'b0;  o.fdf = 1'b1; end
    end
    return o;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_mode[i] = MRun;
      m_cnt[i]  = 0;
      for (int k = 0; k < 3; k++) begin
        m_v[i][k] = 1'b0; m_w[i][k] = 5'd0; m_l[i][k] = 1'b0;
      end
    end
  endtask

  task automatic model_step(input int i);
    obs_t o;
    bit   hz, ms, any_valid;
    o  = model_out(i, hz);
    ms = dmem_req && !dhit;
    if (m_mode[i] == MHalted) return;
    if (!o.pc && (m_mode[i] == MRun || m_mode[i] == MMemWait) && m_cnt[i] < cnt_max(i))
      m_cnt[i]++;
    any_valid = m_v[i][0] || m_v[i][1] || m_v[i][2];
    case (m_mode[i])
      MRun, MMemWait: begin
        if (ms)                                   m_mode[i] = MMemWait;
        else if (dec_halt && !ex_redirect && !hz) m_mode[i] = MDrain;
        else                                      m_mode[i] = MRun;
      end
      MDrain: begin
        if (!ms && ex_redirect)     m_mode[i] = MRun;
        else if (!ms && !any_valid) m_mode[i] = MHalted;
      end
      default: ;
    endcase
    if (!ms) begin
      for (int k = 2; k > 0; k--) begin
        m_v[i][k] = m_v[i][k-1]; m_w[i][k] = m_w[i][k-1]; m_l[i][k] = m_l[i][k-1];
      end
      m_v[i][0] = o.dxf ? 1'b0 : dec_wen;
      m_w[i][0] = dec_wsel;
      m_l[i][0] = o.dxf ? 1'b0 : dec_load;
    end
  endtask

  function automatic obs_t dut_obs(input int i);
    obs_t o;
    o.pc  = pc_en[i]; o.fd = fd_en[i]; o.dx = dx_en[i]; o.xm = xm_en[i]; o.mw = mw_en[i];
    o.fdf = fd_fl[i]; o.dxf = dx_fl[i]; o.fa = fa[i]; o.fb = fb[i]; o.hl = hlt[i];
    case (i)
      0:       o.cnt = cnt0;
      1:       o.cnt = {14'd0, cnt1};
      default: o.cnt = cnt2;
    endcase
    return o;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    bit hz;
    for (int i = 0; i < N; i++)
      check($sformatf("%s_dut%0d", tag, i), 32'(dut_obs(i)), 32'(model_out(i, hz)));
  endtask

  task automatic tick();
    @(negedge CLK);
    if (!nRST) model_reset();
    check_all("cyc");
    @(posedge CLK);
    if (nRST) for (int i = 0; i < N; i++) model_step(i);
    #1;
  endtask

  task automatic set_dec(input logic [4:0] rs, input logic [4:0] rt, input logic urs,
                         input logic urt, input logic [4:0] ws, input logic wen,
                         input logic ld, input logic hl);
    dec_rs = rs; dec_rt = rt; dec_use_rs = urs; dec_use_rt = urt;
    dec_wsel = ws; dec_wen = wen; dec_load = ld; dec_halt = hl;
  endtask

  task automatic do_reset();
    ihit = 1'b1; dmem_req = 1'b0; dhit = 1'b1; ex_redirect = 1'b0;
    set_dec(0, 0, 0, 0, 0, 0, 0, 0);
    nRST = 1'b0;
    #1;
    model_reset();
    check_all("rst");
    @(posedge CLK);
    #1;
    nRST = 1'b1;
  endtask

  initial begin
    nRST = 1'b0;
    do_reset();
    check("rst_pcen", pc_en, 3'b111);
    check("rst_halted", hlt, 3'b000);
    check("rst_cnt0", cnt0, 0);

    // Load-use with forwarding: one bubble, then MEM/WB forward.
    set_dec(2, 0, 1, 0, 5, 1, 1, 0); tick();
    set_dec(5, 1, 1, 1, 6, 1, 0, 0); #1;
    check("lu_pcen", pc_en[0], 0);
    check("lu_fden", fd_en[0], 0);
    check("lu_dxfl", dx_fl[0], 1);
    check("lu_xmen", xm_en[0], 1);
    tick(); #1;
    check("lu_fwda", fa[0], 2);
    check("lu_pcen2", pc_en[0], 1);
    check("lu_cnt", cnt0, 1);
    tick();

    // ALU RAW: forwarded with FWD_EN, two stalls without, three when WB also hazards.
    do_reset();
    set_dec(1, 2, 1, 1, 3, 1, 0, 0); tick();
    set_dec(3, 3, 1, 1, 4, 1, 0, 0); #1;
    check("raw_fwda", fa[0], 1);
    check("raw_fwdb", fb[0], 1);
    check("raw_pc0", pc_en[0], 1);
    check("raw_pc1_c1", pc_en[1], 0);
    tick(); #1;
    check("raw_pc1_c2", pc_en[1], 0);
    tick(); #1;
    check("raw_pc1_c3", pc_en[1], 1);
    check("raw_fwd1", {fa[1], fb[1]}, 0);
    check("raw_pc2_c3", pc_en[2], 0);
    check("raw_cnt1", cnt1, 2);
    tick();

    // r0 is never a hazard source.
    do_reset();
    set_dec(0, 0, 0, 0, 0, 1, 0, 0); tick();
    set_dec(0, 0, 1, 1, 7, 1, 0, 0); #1;
    check("r0_pcen", pc_en, 3'b111);
    check("r0_fwd", {fa[0], fb[0]}, 0);
    tick();

    // Memory wait masks a load-use stall and a redirect; redirect wins once dhit arrives.
    do_reset();
    set_dec(2, 0, 1, 0, 5, 1, 1, 0); tick();
    set_dec(5, 0, 1, 0, 6, 1, 0, 0);
    dmem_req = 1'b1; dhit = 1'b0; ex_redirect = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("mw_en", {pc_en, fd_en, dx_en, xm_en, mw_en}, 0);
      check("mw_fl", {fd_fl, dx_fl}, 0);
      tick();
    end
    dhit = 1'b1; #1;
    check("mw_done_pc", pc_en[0], 1);
    check("mw_done_fl", {fd_fl[0], dx_fl[0], fd_en[0]}, 3'b111);
    check("mw_cnt", cnt0, 3);
    tick();
    ex_redirect = 1'b0; dmem_req = 1'b0; tick();

    // HALT behind three writers: three drain cycles, then halted.
    do_reset();
    for (int w = 1; w <= 3; w++) begin
      set_dec(0, 0, 0, 0, 5'(w), 1, 0, 0); tick();
    end
    set_dec(0, 0, 0, 0, 0, 0, 0, 1); #1;
    check("halt_acc", pc_en[0], 1);
    tick();
    set_dec(0, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      #1;
      check("drain", {pc_en[0], fd_fl[0], hlt[0]}, 3'b010);
      tick();
    end
    #1;
    check("halted", hlt, 3'b111);
    check("halted_en", {pc_en, fd_en, dx_en, xm_en, mw_en}, 0);
    tick();

    // Reset asserted mid-drain.
    do_reset();
    set_dec(2, 0, 1, 0, 5, 1, 1, 0); tick();
    set_dec(5, 0, 1, 0, 6, 1, 0, 0); tick(); tick();
    set_dec(0, 0, 0, 0, 0, 0, 0, 1); tick();
    set_dec(0, 0, 0, 0, 0, 0, 0, 0); #1;
    check("pre_rst_drain", {pc_en[0], fd_fl[0]}, 2'b01);
    check("pre_rst_cnt", cnt0, 1);
    #1;
    nRST = 1'b0;
    #1;
    model_reset();
    check("mid_rst_halted", hlt, 0);
    check("mid_rst_cnt", cnt0, 0);
    check("mid_rst_pc", pc_en, 3'b111);
    nRST = 1'b1;
    tick(); #1;
    check("post_rst_run", {pc_en, fd_fl}, 6'b111000);
    tick();

    // Counter saturation on the 2-bit instance.
    do_reset();
    ihit = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    ihit = 1'b1; #1;
    check("sat_cnt1", cnt1, 3);
    check("sat_cnt0", cnt0, 5);
    tick();

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      nRST        = ($urandom_range(49) != 0);
      ihit        = ($urandom_range(9) != 0);
      dmem_req    = ($urandom_range(9) < 3);
      dhit        = ($urandom_range(9) < 6);
      ex_redirect = ($urandom_range(9) == 0);
      set_dec(5'($urandom_range(7)), 5'($urandom_range(7)), 1'($urandom_range(1)),
              1'($urandom_range(1)), 5'($urandom_range(7)), 1'($urandom_range(1)),
              1'($urandom_range(1)), ($urandom_range(29) == 0));
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
